// File: rtl/cp0_pkg.sv
// Shared CP0 constants: register numbers, exception codes, Status bit layout
// and the exception-sequencing state enum.
package cp0_pkg;
   localparam logic [4:0]  CP0_STATUS   = 5'd12;
   localparam logic [4:0]  CP0_CAUSE    = 5'd13;
   localparam logic [4:0]  CP0_EPC      = 5'd14;

   localparam logic [4:0]  EXC_INT      = 5'd0;
   localparam logic [4:0]  EXC_ADEL     = 5'd4;
   localparam logic [4:0]  EXC_ADES     = 5'd5;
   localparam logic [4:0]  EXC_RI       = 5'd10;

   localparam int          STATUS_IE    = 0;
   localparam int          STATUS_EXL   = 1;
   localparam int          STATUS_IM_LO = 8;
   localparam int          STATUS_IM_HI = 9;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_TRAP = 1'b1
   } cp0_state_e;
endpackage

// File: rtl/cp0_regfile.sv
// Status/Cause/EPC storage with exception, eret and mtc0 update paths,
// plus the combinational mfc0 read mux.
module cp0_regfile
   import cp0_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic [1:0]  ext_int,
   input  logic        exc_take,
   input  logic [4:0]  exc_code,
   input  logic [31:0] exc_epc,
   input  logic        eret_take,
   input  logic        mtc_take,
   input  logic [4:0]  cp0_addr,
   input  logic [31:0] mtc_data,
   output logic [31:0] mfc_data,
   output logic [31:0] status,
   output logic [31:0] cause,
   output logic [31:0] epc
);
   logic        ie_q, ie_d;
   logic        exl_q, exl_d;
   logic [1:0]  im_q, im_d;
   logic [1:0]  ip_q, ip_d;
   logic [4:0]  exc_code_q, exc_code_d;
   logic [31:0] epc_q, epc_d;

   always_comb begin
      ie_d       = ie_q;
      exl_d      = exl_q;
      im_d       = im_q;
      exc_code_d = exc_code_q;
      epc_d      = epc_q;
      ip_d       = ext_int;
      if (exc_take) begin
         exl_d      = 1'b1;
         epc_d      = exc_epc;
         exc_code_d = exc_code;
      end else if (eret_take) begin
         exl_d = 1'b0;
      end else if (mtc_take) begin
         // Cause and unimplemented register numbers are read-only to software.
         case (cp0_addr)
            CP0_STATUS: begin
               ie_d  = mtc_data[STATUS_IE];
               exl_d = mtc_data[STATUS_EXL];
               im_d  = mtc_data[STATUS_IM_HI:STATUS_IM_LO];
            end
            CP0_EPC: epc_d = mtc_data;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ie_q       <= 1'b0;
         exl_q      <= 1'b0;
         im_q       <= 2'b00;
         ip_q       <= 2'b00;
         exc_code_q <= 5'd0;
         epc_q      <= 32'd0;
      end else begin
         ie_q       <= ie_d;
         exl_q      <= exl_d;
         im_q       <= im_d;
         ip_q       <= ip_d;
         exc_code_q <= exc_code_d;
         epc_q      <= epc_d;
      end
   end

   assign status = {22'd0, im_q, 6'd0, exl_q, ie_q};
   assign cause  = {22'd0, ip_q, 1'b0, exc_code_q, 2'b00};
   assign epc    = epc_q;

   always_comb begin
      mfc_data = 32'd0;
      case (cp0_addr)
         CP0_STATUS: mfc_data = status;
         CP0_CAUSE:  mfc_data = cause;
         CP0_EPC:    mfc_data = epc;
         default:    mfc_data = 32'd0;
      endcase
   end
endmodule

// File: rtl/cp0_exception_ctrl.sv
// CP0 exception controller: prioritises EXE/ID faults, interrupts, eret and
// mtc0, sequences the one-cycle TRAP redirect and drives pipeline kills.
module cp0_exception_ctrl
   import cp0_pkg::*;
#(
   parameter logic [31:0] HANDLER_PC = 32'h0000_0008
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        id_valid,
   input  logic [31:0] id_pc,
   input  logic [31:0] exe_pc,
   input  logic        undef_exc,
   input  logic        mem_range_exc,
   input  logic        exe_is_sw,
   input  logic [1:0]  ext_int,
   input  logic        is_mtc,
   input  logic        is_mfc,
   input  logic        is_eret,
   input  logic [4:0]  cp0_addr,
   input  logic [31:0] mtc_data,
   output logic [31:0] mfc_data,
   output logic        kill_id,
   output logic        kill_exe,
   output logic        redirect_valid,
   output logic [31:0] redirect_pc,
   output logic        flush_if,
   output logic [31:0] status,
   output logic [31:0] cause,
   output logic [31:0] epc,
   output cp0_state_e  state_dbg
);
   cp0_state_e  state_q, state_d;
   logic        exc_take, eret_take, mtc_take, int_pend;
   logic [4:0]  exc_code;
   logic [31:0] exc_epc;
   logic        is_idle;

   assign is_idle  = (state_q == ST_IDLE);
   assign int_pend = status[STATUS_IE] && !status[STATUS_EXL] &&
                     |(cause[9:8] & status[STATUS_IM_HI:STATUS_IM_LO]) &&
                     id_valid && is_idle;

   always_comb begin
      state_d        = state_q;
      exc_take       = 1'b0;
      eret_take      = 1'b0;
      mtc_take       = 1'b0;
      exc_code       = EXC_INT;
      exc_epc        = id_pc;
      kill_id        = 1'b0;
      kill_exe       = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = 32'd0;
      flush_if       = 1'b0;
      if (!is_idle) begin
         // TRAP lasts exactly one cycle and masks every new event.
         state_d        = ST_IDLE;
         redirect_valid = 1'b1;
         redirect_pc    = HANDLER_PC;
         flush_if       = 1'b1;
         kill_id        = 1'b1;
      end else if (mem_range_exc) begin
         exc_take = 1'b1;
         exc_code = exe_is_sw ? EXC_ADES : EXC_ADEL;
         exc_epc  = exe_pc;
         kill_exe = 1'b1;
         kill_id  = 1'b1;
         state_d  = ST_TRAP;
      end else if (undef_exc || int_pend) begin
         exc_take = 1'b1;
         exc_code = undef_exc ? EXC_RI : EXC_INT;
         kill_id  = 1'b1;
         state_d  = ST_TRAP;
      end else if (is_eret) begin
         eret_take      = 1'b1;
         redirect_valid = 1'b1;
         redirect_pc    = epc;
         flush_if       = 1'b1;
      end else if (is_mtc) begin
         mtc_take = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) state_q <= ST_IDLE;
      else     state_q <= state_d;
   end

   assign state_dbg = state_q;

   cp0_regfile u_regfile (
      .clk       (clk),
      .rst       (rst),
      .ext_int   (ext_int),
      .exc_take  (exc_take),
      .exc_code  (exc_code),
      .exc_epc   (exc_epc),
      .eret_take (eret_take),
      .mtc_take  (mtc_take),
      .cp0_addr  (cp0_addr),
      .mtc_data  (mtc_data),
      .mfc_data  (mfc_data),
      .status    (status),
      .cause     (cause),
      .epc       (epc)
   );

   // mfc0 needs no side effect here; the read mux is purely address-driven.
   logic unused_ok;
   assign unused_ok = is_mfc;
endmodule

// File: tb/tb_cp0_exception_ctrl.sv
// Directed bench for cp0_exception_ctrl: traps, priority, interrupts,
// eret/mtc0 paths and reset during TRAP.
module tb_cp0_exception_ctrl;
   import cp0_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        id_valid;
   logic [31:0] id_pc;
   logic [31:0] exe_pc;
   logic        undef_exc;
   logic        mem_range_exc;
   logic        exe_is_sw;
   logic [1:0]  ext_int;
   logic        is_mtc, is_mfc, is_eret;
   logic [4:0]  cp0_addr;
   logic [31:0] mtc_data;
   logic [31:0] mfc_data;
   logic        kill_id, kill_exe, redirect_valid, flush_if;
   logic [31:0] redirect_pc, status, cause, epc;
   cp0_state_e  state_dbg;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   cp0_exception_ctrl #(.HANDLER_PC(32'h0000_0008)) dut (
      .clk            (clk),
      .rst            (rst),
      .id_valid       (id_valid),
      .id_pc          (id_pc),
      .exe_pc         (exe_pc),
      .undef_exc      (undef_exc),
      .mem_range_exc  (mem_range_exc),
      .exe_is_sw      (exe_is_sw),
      .ext_int        (ext_int),
      .is_mtc         (is_mtc),
      .is_mfc         (is_mfc),
      .is_eret        (is_eret),
      .cp0_addr       (cp0_addr),
      .mtc_data       (mtc_data),
      .mfc_data       (mfc_data),
      .kill_id        (kill_id),
      .kill_exe       (kill_exe),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .flush_if       (flush_if),
      .status         (status),
      .cause          (cause),
      .epc            (epc),
      .state_dbg      (state_dbg)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // Advance one edge; inputs then change 1ns after it, well away from the next edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   initial begin
      rst = 1'b1; id_valid = 1'b0; id_pc = '0; exe_pc = '0; undef_exc = 1'b0;
      mem_range_exc = 1'b0; exe_is_sw = 1'b0; ext_int = 2'b00;
      is_mtc = 1'b0; is_mfc = 1'b0; is_eret = 1'b0; cp0_addr = '0; mtc_data = '0;
      tick(); tick();
      rst = 1'b0;
      settle();
      chk("rst_status", status, 32'h0);
      chk("rst_cause", cause, 32'h0);
      chk("rst_epc", epc, 32'h0);
      chk("rst_redirect", {31'd0, redirect_valid}, 32'd0);
      chk("rst_kill", {30'd0, kill_id, kill_exe}, 32'd0);
      chk("rst_state", {31'd0, state_dbg}, {31'd0, ST_IDLE});

      // Load address fault in EXE
      id_valid = 1'b1; id_pc = 32'h44; exe_pc = 32'h40; mem_range_exc = 1'b1; exe_is_sw = 1'b0;
      settle();
      chk("adel_kill_exe", {31'd0, kill_exe}, 32'd1);
      chk("adel_kill_id", {31'd0, kill_id}, 32'd1);
      chk("adel_no_redir_n", {31'd0, redirect_valid}, 32'd0);
      tick();
      mem_range_exc = 1'b0;
      settle();
      chk("adel_epc", epc, 32'h40);
      chk("adel_cause", cause, 32'h10);
      chk("adel_status", status, 32'h2);
      chk("adel_redir_v", {31'd0, redirect_valid}, 32'd1);
      chk("adel_redir_pc", redirect_pc, 32'h8);
      chk("adel_flush", {31'd0, flush_if}, 32'd1);
      chk("adel_trap_kill_id", {31'd0, kill_id}, 32'd1);
      tick();
      chk("adel_back_idle", {31'd0, redirect_valid}, 32'd0);

      // EXE store fault and ID undefined together; faults held into TRAP must be ignored
      mem_range_exc = 1'b1; exe_is_sw = 1'b1; undef_exc = 1'b1; exe_pc = 32'h20; id_pc = 32'h24;
      settle();
      chk("both_kill_id", {31'd0, kill_id}, 32'd1);
      tick();
      exe_pc = 32'h99;
      settle();
      chk("both_epc", epc, 32'h20);
      chk("both_cause", cause, 32'h14);
      chk("both_trap", {31'd0, redirect_valid}, 32'd1);
      chk("trap_ignores_exe", {31'd0, kill_exe}, 32'd0);
      tick();
      mem_range_exc = 1'b0; undef_exc = 1'b0; exe_is_sw = 1'b0;
      settle();
      chk("both_one_trap", {31'd0, redirect_valid}, 32'd0);
      chk("both_epc_kept", epc, 32'h20);

      // mtc0 EPC then eret
      is_mtc = 1'b1; cp0_addr = CP0_EPC; mtc_data = 32'h200;
      tick();
      is_mtc = 1'b0; is_mfc = 1'b1;
      settle();
      chk("mtc_epc", epc, 32'h200);
      chk("mfc_epc", mfc_data, 32'h200);
      is_mfc = 1'b0; is_eret = 1'b1;
      settle();
      chk("eret_redir_v", {31'd0, redirect_valid}, 32'd1);
      chk("eret_redir_pc", redirect_pc, 32'h200);
      chk("eret_flush", {31'd0, flush_if}, 32'd1);
      chk("eret_no_kill", {30'd0, kill_id, kill_exe}, 32'd0);
      tick();
      is_eret = 1'b0;
      settle();
      chk("eret_exl_clr", status, 32'h0);

      // Status write masking, then an interrupt
      is_mtc = 1'b1; cp0_addr = CP0_STATUS; mtc_data = 32'hFFFF_FCFD;
      tick();
      chk("status_mask", status, 32'h1);
      mtc_data = 32'h301;
      tick();
      is_mtc = 1'b0;
      chk("status_301", status, 32'h301);
      ext_int = 2'b01; id_valid = 1'b1; id_pc = 32'h100;
      settle();
      chk("int_before_ip", {31'd0, kill_id}, 32'd0);
      tick();
      chk("int_ip_sampled", cause, 32'h114);
      chk("int_kill_id", {31'd0, kill_id}, 32'd1);
      chk("int_kill_exe", {31'd0, kill_exe}, 32'd0);
      tick();
      chk("int_epc", epc, 32'h100);
      chk("int_cause", cause, 32'h100);
      chk("int_status", status, 32'h303);
      chk("int_redir_v", {31'd0, redirect_valid}, 32'd1);
      tick();
      chk("int_exl_block", {31'd0, kill_id}, 32'd0);
      chk("int_exl_no_redir", {31'd0, redirect_valid}, 32'd0);
      tick();
      chk("int_exl_block2", {31'd0, state_dbg}, {31'd0, ST_IDLE});

      // mtc0 to Cause is dropped
      is_mtc = 1'b1; cp0_addr = CP0_CAUSE; mtc_data = 32'hFFFF_FFFF;
      settle();
      chk("mfc_cause_prior", mfc_data, 32'h100);
      tick();
      is_mtc = 1'b0;
      chk("cause_unchanged", cause, 32'h100);

      // Undefined instruction, then reset during its TRAP
      ext_int = 2'b00; undef_exc = 1'b1; id_pc = 32'h300;
      settle();
      chk("ri_kill_id", {31'd0, kill_id}, 32'd1);
      chk("ri_kill_exe", {31'd0, kill_exe}, 32'd0);
      tick();
      undef_exc = 1'b0;
      chk("ri_cause", cause, 32'h28);
      chk("ri_epc", epc, 32'h300);
      chk("ri_state", {31'd0, state_dbg}, {31'd0, ST_TRAP});
      rst = 1'b1; mem_range_exc = 1'b1; exe_pc = 32'h77;
      tick();
      rst = 1'b0; mem_range_exc = 1'b0;
      settle();
      chk("rst_trap_status", status, 32'h0);
      chk("rst_trap_cause", cause, 32'h0);
      chk("rst_trap_epc", epc, 32'h0);
      chk("rst_trap_redir", {31'd0, redirect_valid}, 32'd0);
      chk("rst_trap_state", {31'd0, state_dbg}, {31'd0, ST_IDLE});

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
